// File: rtl/product_accumulator_if.sv
// Stream bundle between the multiplier array and the product accumulator:
// an input beat channel and a result channel, each with valid/ready.
interface product_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int NUM        = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM-1:0][DATA_WIDTH-1:0]   in_data;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [ACC_WIDTH-1:0]             out_data;
  logic [15:0]                      out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/product_accumulator.sv
// Reduces NUM products per beat through a registered adder tree and accumulates
// beats into a dot-product sum, emitted with its beat count on each last beat.
module product_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int NUM        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  localparam int L        = (NUM > 1) ? $clog2(NUM) : 0;
  localparam int W        = 1 << L;
  localparam int PAD_BITS = W * DATA_WIDTH;

  logic                       advance;
  logic                       out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]       out_data_q, out_data_d;
  logic [15:0]                out_count_q, out_count_d;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       fresh_q, fresh_d;

  logic [PAD_BITS-1:0]              in_flat;
  logic [W-1:0][DATA_WIDTH-1:0]     in_pad;

  // One stall signal freezes every stage, so nothing is lost or duplicated.
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Zero-extending the packed beat pads a non power-of-two NUM with zero products.
  assign in_flat = PAD_BITS'(bus.in_data);
  assign in_pad  = in_flat;

  for (genvar k = 0; k <= L; k++) begin : lvl
    localparam int N = W >> k;

    logic [ACC_WIDTH-1:0] sum_d [N];
    logic [ACC_WIDTH-1:0] sum_q [N];
    logic                 valid_d, valid_q;
    logic                 last_d, last_q;

    if (k == 0) begin : g_in
      always_comb begin
        valid_d = bus.in_valid;
        last_d  = bus.in_last;
        for (int i = 0; i < N; i++) begin
          sum_d[i] = ACC_WIDTH'(signed'(in_pad[i]));
        end
      end
    end else begin : g_add
      always_comb begin
        valid_d = lvl[k-1].valid_q;
        last_d  = lvl[k-1].last_q;
        for (int i = 0; i < N; i++) begin
          sum_d[i] = lvl[k-1].sum_q[2*i] + lvl[k-1].sum_q[2*i+1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_d;
        last_q  <= last_d;
        sum_q   <= sum_d;
      end
    end
  end

  logic [ACC_WIDTH-1:0] tail_sum;
  logic                 tail_valid;
  logic                 tail_last;
  logic [ACC_WIDTH-1:0] base_acc;
  logic [15:0]          base_cnt;
  logic [ACC_WIDTH-1:0] grp_sum;
  logic [15:0]          grp_cnt;

  assign tail_sum   = lvl[L].sum_q[0];
  assign tail_valid = lvl[L].valid_q;
  assign tail_last  = lvl[L].last_q;

  // A fresh group ignores whatever acc/cnt still hold from the previous one.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fresh_d     = fresh_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    base_acc    = fresh_q ? '0 : acc_q;
    base_cnt    = fresh_q ? '0 : cnt_q;
    grp_sum     = base_acc + tail_sum;
    grp_cnt     = (base_cnt == 16'hFFFF) ? base_cnt : base_cnt + 16'd1;
    if (advance) begin
      if (out_valid_q) begin
        out_valid_d = 1'b0;
      end
      if (tail_valid) begin
        if (tail_last) begin
          out_data_d  = grp_sum;
          out_count_d = grp_cnt;
          out_valid_d = 1'b1;
          fresh_d     = 1'b1;
        end else begin
          acc_d   = grp_sum;
          cnt_d   = grp_cnt;
          fresh_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      fresh_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fresh_q     <= fresh_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule
